vga_scan_gen: RTL and testbench
===============================

# vga_scan_gen

Raster scan generator driving the VGA port and feeding pixel coordinates to `color_mapper`.
- Produces `DrawX`/`DrawY`, the sync/blank strobes, the pixel clock and a frame-start pulse.
- Takes `color_mapper`'s combinational Red/Green/Blue back in, blanks it, and forwards it to the DAC pins.
- Sits between the top level and the DAC/connector; one instance per design.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel; must be even and ≥2

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-low reset
- Red_in, Green_in, Blue_in  in  8 each  pixel colour from color_mapper for the current DrawX/DrawY
- DrawX  out  10  current horizontal count, 0..799
- DrawY  out  10  current vertical count, 0..524
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = active video, 0 = blanking
- sync  out  1  composite sync, tied 0
- pixel_clk  out  1  DAC pixel clock
- frame_start  out  1  one-Clk pulse at start of each frame
- VGA_R, VGA_G, VGA_B  out  8 each  colour to DAC

## Operation
- Divider `div` counts 0..CLK_DIV-1. `pix_en` = (div == CLK_DIV-1). `pixel_clk` = (div ≥ CLK_DIV/2), registered.
- The horizontal counter `hc` advances on each `pix_en`. H_TOTAL = 800 with the defaults. It wraps H_TOTAL-1 → 0.
- The vertical counter `vc` increments only when `hc` wraps. V_TOTAL = 525 with the defaults. It wraps V_TOTAL-1 → 0.
- DrawX = hc and DrawY = vc, both registered.
- hs = 0 iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs = 0 iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC (490..491).
- blank = 1 iff hc < H_ACTIVE and vc < V_ACTIVE.
- hs, vs and blank are registered from the next counter values, so they always describe the DrawX/DrawY being presented.
- frame_start = 1 for exactly the Clk cycle following the pix_en edge on which (hc,vc) becomes (0,0).
- VGA_R/G/B = blank ? Red_in/Green_in/Blue_in : 0. Colour is never driven during blanking.
- Reset is asynchronous and takes effect immediately, including mid-line or mid-frame:
  - div=0, hc=0, vc=0, DrawX=0, DrawY=0.
  - hs=1, vs=1, blank=0, frame_start=0, pixel_clk=0, VGA_R/G/B=0.
- After Reset deasserts, blank stays 0 until the first pix_en; from then on the strobes follow the counters. The scan restarts from (0,0) with no frame_start for the first frame.

## Timing
- State changes happen only on rising Clk edges with pix_en=1. That edge coincides with the falling edge of pixel_clk, so the DAC samples on the pixel_clk rising edge, mid-pixel.
- Default timings:
  - Line = 800 pixels = 1600 Clk.
  - hs low for 96 pixels = 192 Clk.
  - Frame = 525 lines = 840000 Clk, giving ≈59.5 Hz.
- Colour path latency without the macro is 0 pixels: Red_in is combinational from DrawX/DrawY within the same pixel.

## Configuration
- Macro `VGA_RGB_REG_EN`.
- Defined:
  - VGA_R/G/B are registered on pix_en from blank-gated Red_in/Green_in/Blue_in.
  - hs, vs and blank outputs are delayed one pixel (one pix_en) to stay aligned with the registered colour.
  - DrawX/DrawY and frame_start are not delayed.
  - The colour for coordinate (x,y) appears on the pins one pixel period after DrawX=x.
  - The delay registers reset to hs=1, vs=1, blank=0, RGB=0.
- Undefined: purely combinational colour gating as described in Operation.

## Test plan
- Reset asserted mid-frame at (hc=300, vc=200) → within the same cycle all outputs take their reset values. After release, the first pix_en gives DrawX=1, DrawY=0, blank=1.
- Free-run one line → hs falls when DrawX goes 655→656, rises at 751→752 (192 Clk low). blank falls at 639→640. DrawX wraps 799→0 and DrawY increments.
- Free-run a full frame → vs low exactly for DrawY 490..491. frame_start pulses once every 840000 Clk. DrawY wraps 524→0.
- Red_in/Green_in/Blue_in held at 0xFF/0x80/0x11:
  - DrawX<640, DrawY<480 → VGA_R/G/B = FF/80/11.
  - DrawX=640 or DrawY=480 → 00/00/00.
- pixel_clk period is 2 Clk with 50% duty. pix_en edges coincide with pixel_clk falling edges.
- With `VGA_RGB_REG_EN` and Red_in driven as DrawX[7:0]:
  - The VGA_R value lags DrawX by exactly one pixel.
  - hs/blank transitions shift one pixel later (hs low at DrawX 657..752).
  - DrawX timing is unchanged.

Source files
------------

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel-clock divider, h/v counters, sync/blank strobes and colour gating.
// Optional macro VGA_RGB_REG_EN registers the colour path and delays hs/vs/blank by one pixel to match.
`timescale 1ns/1ps

module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic       pixel_clk,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hc_q, hc_d;
    logic [9:0]       vc_q, vc_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             pclk_q, pclk_d;
    logic             fs_q, fs_d;
    logic             pix_en;

    // Strobes are computed from the next counter values so they describe the pixel being presented.
    always_comb begin
        pix_en  = (div_q == DIV_LAST);
        div_d   = pix_en ? '0 : div_q + DIV_ONE;
        pclk_d  = (div_d >= DIV_HALF);
        hc_d    = hc_q;
        vc_d    = vc_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        if (pix_en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
            hs_d    = !((hc_d >= HS_START) && (hc_d < HS_END));
            vs_d    = !((vc_d >= VS_START) && (vc_d < VS_END));
            blank_d = (hc_d < H_VIS) && (vc_d < V_VIS);
        end
        fs_d = pix_en && (hc_d == '0) && (vc_d == '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            pclk_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            pclk_q  <= pclk_d;
            fs_q    <= fs_d;
        end
    end

    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign pixel_clk   = pclk_q;
    assign frame_start = fs_q;
    assign sync        = 1'b0;

`ifdef VGA_RGB_REG_EN
    logic       hs_dly_q, hs_dly_d;
    logic       vs_dly_q, vs_dly_d;
    logic       blank_dly_q, blank_dly_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;

    // Colour is captured at the end of its pixel, so the strobes ride one pixel behind with it.
    always_comb begin
        hs_dly_d    = hs_dly_q;
        vs_dly_d    = vs_dly_q;
        blank_dly_d = blank_dly_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        if (pix_en) begin
            hs_dly_d    = hs_q;
            vs_dly_d    = vs_q;
            blank_dly_d = blank_q;
            r_d         = blank_q ? Red_in   : 8'h00;
            g_d         = blank_q ? Green_in : 8'h00;
            b_d         = blank_q ? Blue_in  : 8'h00;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hs_dly_q    <= 1'b1;
            vs_dly_q    <= 1'b1;
            blank_dly_q <= 1'b0;
            r_q         <= 8'h00;
            g_q         <= 8'h00;
            b_q         <= 8'h00;
        end else begin
            hs_dly_q    <= hs_dly_d;
            vs_dly_q    <= vs_dly_d;
            blank_dly_q <= blank_dly_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign hs    = hs_dly_q;
    assign vs    = vs_dly_q;
    assign blank = blank_dly_q;
    assign VGA_R = r_q;
    assign VGA_G = g_q;
    assign VGA_B = b_q;
`else
    assign hs    = hs_q;
    assign vs    = vs_q;
    assign blank = blank_q;
    assign VGA_R = blank_q ? Red_in   : 8'h00;
    assign VGA_G = blank_q ? Green_in : 8'h00;
    assign VGA_B = blank_q ? Blue_in  : 8'h00;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen: default horizontal timing with a shortened 10-line frame so whole
// frames fit in a short run; a cycle model feeds a scoreboard, plus colour vectors and edge sequences.
`timescale 1ns/1ps

module tb_vga_scan_gen;

    localparam int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_ACTIVE = 4, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int CLK_DIV  = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;
`ifdef VGA_RGB_REG_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic       Clk   = 1'b0;
    logic       Reset = 1'b1;
    logic       track = 1'b0;
    logic [7:0] col_r = 8'h00, col_g = 8'h00, col_b = 8'h00;
    logic [7:0] Red_in, Green_in, Blue_in;
    logic [9:0] DrawX, DrawY;
    logic       hs, vs, blank, sync, pixel_clk, frame_start;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    assign Red_in   = track ? DrawX[7:0] : col_r;
    assign Green_in = col_g;
    assign Blue_in  = col_b;

    vga_scan_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
        .DrawX(DrawX), .DrawY(DrawY), .hs(hs), .vs(vs), .blank(blank), .sync(sync),
        .pixel_clk(pixel_clk), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #10 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model of the scan, stepped once per Clk.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs, vs, blank, fs, pclk;
        logic [7:0] r, g, b;
    } obs_t;

    obs_t sb[$];
    obs_t exp_obs, act_obs;

    int         m_div, m_x, m_y;
    logic       m_hs, m_vs, m_blank, m_fs, m_pclk;
    logic       m_hs_o, m_vs_o, m_blank_o;
    logic [7:0] m_r, m_g, m_b;

    function automatic logic [7:0] red_for(int x);
        return track ? 8'(x) : col_r;
    endfunction

    task automatic m_reset();
        m_div = 0; m_x = 0; m_y = 0;
        m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0; m_fs = 1'b0; m_pclk = 1'b0;
        m_hs_o = 1'b1; m_vs_o = 1'b1; m_blank_o = 1'b0;
        m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
    endtask

    task automatic m_step();
        bit pe;
        pe     = (m_div == CLK_DIV - 1);
        m_div  = pe ? 0 : m_div + 1;
        m_pclk = (m_div >= CLK_DIV / 2);
        m_fs   = 1'b0;
        if (pe) begin
            m_hs_o    = m_hs;
            m_vs_o    = m_vs;
            m_blank_o = m_blank;
            m_r = m_blank ? red_for(m_x) : 8'h00;
            m_g = m_blank ? col_g : 8'h00;
            m_b = m_blank ? col_b : 8'h00;
            m_x = m_x + 1;
            if (m_x == H_TOTAL) begin
                m_x = 0;
                m_y = (m_y + 1) % V_TOTAL;
            end
            m_fs    = (m_x == 0) && (m_y == 0);
            m_hs    = !(m_x >= H_ACTIVE + H_FP && m_x < H_ACTIVE + H_FP + H_SYNC);
            m_vs    = !(m_y >= V_ACTIVE + V_FP && m_y < V_ACTIVE + V_FP + V_SYNC);
            m_blank = (m_x < H_ACTIVE) && (m_y < V_ACTIVE);
        end
    endtask

    function automatic obs_t m_expect();
        obs_t e;
        e.x = 10'(m_x); e.y = 10'(m_y); e.fs = m_fs; e.pclk = m_pclk;
`ifdef VGA_RGB_REG_EN
        e.hs = m_hs_o; e.vs = m_vs_o; e.blank = m_blank_o;
        e.r = m_r; e.g = m_g; e.b = m_b;
`else
        e.hs = m_hs; e.vs = m_vs; e.blank = m_blank;
        e.r = m_blank ? red_for(m_x) : 8'h00;
        e.g = m_blank ? col_g : 8'h00;
        e.b = m_blank ? col_b : 8'h00;
`endif
        return e;
    endfunction

    // Expected values are pushed once stimulus for the cycle has settled, popped mid-cycle.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_reset();
            sb.delete();
        end else begin
            m_step();
            #2;
            sb.push_back(m_expect());
        end
    end

    always @(negedge Clk) begin
        if (Reset && sb.size() > 0) begin
            exp_obs = sb.pop_front();
            act_obs = {DrawX, DrawY, hs, vs, blank, frame_start, pixel_clk, VGA_R, VGA_G, VGA_B};
            checks++;
            if (act_obs !== exp_obs) begin
                errors++;
                $display("[TB] FAIL scan cycle %0d: got %h, expected %h", cyc, act_obs, exp_obs);
            end
        end
    end

    task automatic check_output(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic report_timeout(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out, wanted event did not occur", name);
    endtask

    task automatic apply_stimulus(logic [7:0] r, logic [7:0] g, logic [7:0] b);
        @(posedge Clk);
        #1;
        col_r = r; col_g = g; col_b = b;
    endtask

    task automatic wait_xy(int x, int y, int limit, string name);
        int n = 0;
        while (!(DrawX == 10'(x) && DrawY == 10'(y)) && n < limit) begin
            @(negedge Clk);
            n++;
        end
        if (n >= limit) report_timeout(name);
    endtask

    task automatic wait_pix(output logic pclk_before);
        logic [9:0] prev;
        int n = 0;
        prev        = DrawX;
        pclk_before = pixel_clk;
        while (DrawX == prev && n < 4 * CLK_DIV) begin
            pclk_before = pixel_clk;
            @(negedge Clk);
            n++;
        end
        if (n >= 4 * CLK_DIV) report_timeout("pixel advance");
    endtask

    task automatic check_reset_outputs(string tag);
        check_output({tag, " DrawX"}, int'(DrawX), 0);
        check_output({tag, " DrawY"}, int'(DrawY), 0);
        check_output({tag, " hs"}, int'(hs), 1);
        check_output({tag, " vs"}, int'(vs), 1);
        check_output({tag, " blank"}, int'(blank), 0);
        check_output({tag, " frame_start"}, int'(frame_start), 0);
        check_output({tag, " pixel_clk"}, int'(pixel_clk), 0);
        check_output({tag, " RGB"}, int'({VGA_R, VGA_G, VGA_B}), 0);
    endtask

    typedef struct {
        int         x;
        int         y;
        logic [7:0] r_in, g_in, b_in;
        logic [7:0] r_exp, g_exp, b_exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic pb;
        int   n, t0, t1, y0;

        vecs[0] = '{10,  1, 8'hFF, 8'h80, 8'h11, 8'hFF, 8'h80, 8'h11};
        vecs[1] = '{640, 1, 8'hFF, 8'h80, 8'h11, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{200, 3, 8'h3C, 8'hA5, 8'h5A, 8'h3C, 8'hA5, 8'h5A};
        vecs[3] = '{639, 3, 8'hFF, 8'h80, 8'h11, 8'hFF, 8'h80, 8'h11};
        vecs[4] = '{100, 4, 8'hFF, 8'h80, 8'h11, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{799, 9, 8'hFF, 8'h80, 8'h11, 8'h00, 8'h00, 8'h00};

        #1 Reset = 1'b0;
        #1 check_reset_outputs("power-on reset");
        repeat (3) @(negedge Clk);
        #3 Reset = 1'b1;

        // Colour gating vectors, visited in scan order within the first frame.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i].r_in, vecs[i].g_in, vecs[i].b_in);
            wait_xy(vecs[i].x, vecs[i].y, FRAME_CLK + 100, $sformatf("reach vec %0d", i));
            @(negedge Clk);
            if (LAG != 0) wait_pix(pb);
            check_output($sformatf("vec %0d VGA_R", i), int'(VGA_R), int'(vecs[i].r_exp));
            check_output($sformatf("vec %0d VGA_G", i), int'(VGA_G), int'(vecs[i].g_exp));
            check_output($sformatf("vec %0d VGA_B", i), int'(VGA_B), int'(vecs[i].b_exp));
        end

        @(posedge Clk);
        #1 track = 1'b1; col_g = 8'h5A; col_b = 8'hC3;
        @(negedge Clk);

        n = 0;
        while (!frame_start && n < FRAME_CLK + 100) begin @(negedge Clk); n++; end
        if (n >= FRAME_CLK + 100) report_timeout("first frame_start");
        t0 = cyc;

        n = 0;
        while (!blank && n < 100) begin @(negedge Clk); n++; end
        while (blank && n < 2000) begin @(negedge Clk); n++; end
        if (n >= 2000) report_timeout("blank fall");
        check_output("blank fall DrawX", int'(DrawX), H_ACTIVE + LAG);

        wait_xy(655, int'(DrawY), 400, "reach DrawX 655");
        n = 0;
        while (hs && n < 20) begin @(negedge Clk); n++; end
        if (n >= 20) report_timeout("hs fall");
        check_output("hs fall DrawX", int'(DrawX), 656 + LAG);
        t1 = cyc;
        n = 0;
        while (!hs && n < 400) begin @(negedge Clk); n++; end
        if (n >= 400) report_timeout("hs rise");
        check_output("hs low Clk count", cyc - t1, H_SYNC * CLK_DIV);
        check_output("hs rise DrawX", int'(DrawX), 752 + LAG);

        wait_xy(799, int'(DrawY), 200, "reach DrawX 799");
        y0 = int'(DrawY);
        wait_pix(pb);
        check_output("line wrap DrawX", int'(DrawX), 0);
        check_output("line wrap DrawY", int'(DrawY), (y0 + 1) % V_TOTAL);
        check_output("pixel_clk high before pix edge", int'(pb), 1);
        check_output("pixel_clk low after pix edge", int'(pixel_clk), 0);

        n = 0;
        while (frame_start && n < 10) begin @(negedge Clk); n++; end
        n = 0;
        while (!frame_start && n < FRAME_CLK + 100) begin @(negedge Clk); n++; end
        if (n >= FRAME_CLK + 100) report_timeout("second frame_start");
        check_output("frame_start interval", cyc - t0, FRAME_CLK);

        // Asynchronous reset landing in the middle of a visible line.
        wait_xy(300, 2, FRAME_CLK + 100, "reach (300,2)");
        @(posedge Clk);
        #5 Reset = 1'b0;
        #1 check_reset_outputs("mid-frame reset");
        repeat (2) @(negedge Clk);
        #3 Reset = 1'b1;
        n = 0;
        while (DrawX == 10'd0 && n < 6) begin @(negedge Clk); n++; end
        check_output("first pix_en after reset, negedges", n, CLK_DIV);
        check_output("post-reset DrawX", int'(DrawX), 1);
        check_output("post-reset DrawY", int'(DrawY), 0);
        check_output("post-reset blank", int'(blank), (LAG == 0) ? 1 : 0);

        repeat (2 * H_TOTAL * CLK_DIV) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
